alu_seq_param: RTL and testbench
================================

Name: alu_seq_param

Overview:
- Parametrised, registered successor to the team's 64-bit combinational ALU.
- Executes add, sub, and, or, xor, sll, srl, sra, slt and sltu with 1-cycle latency.
- Adds an iterative shift-add multiply, registered status flags and valid/ready handshakes on both sides.
- Sits between the decode/operand-read stage and writeback of the processor datapath.

Parameters:
- WIDTH, 64: operand and result width; legal values are powers of two from 8 to 64.
- MUL_EN, 1: 1 enables the MUL op; 0 makes op 10 illegal and removes the multiply datapath.
- SHW, $clog2(WIDTH): shift-amount width. Derived; not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of in-flight multiply and pending output
- in_valid  in  1  operation request valid
- in_ready  out  1  block can accept an operation this cycle
- op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11-15 illegal
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; shifts use only b[SHW-1:0]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  registered result
- flag_zero  out  1  result == 0
- flag_carry  out  1  carry/no-borrow; for MUL, unsigned overflow
- flag_overflow  out  1  signed overflow, ADD/SUB only
- flag_illegal  out  1  op was illegal
- busy  out  1  multiply in progress

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; out_valid, busy and all flags are 0; result=0.
  - in_ready=0 while rst_n is low.
  - Any in-flight multiply is discarded; there is no partial output.
- States:
  - IDLE: accepts ops.
  - MUL: iterating.
  - There is no separate output-hold state. out_valid is an independent register.
- in_ready is 1 only when state==IDLE, flush==0, and (out_valid==0 or out_ready==1).
  - Acceptance is in_valid & in_ready at a rising edge.
- Single-cycle ops (everything except MUL):
  - result and flags are loaded on the acceptance edge; out_valid=1 from the next cycle (latency 1).
  - Back-to-back throughput is one op per cycle when out_ready is held high.
- Output hold:
  - While out_valid & ~out_ready, result and flags stay stable and in_ready=0.
  - out_valid clears on the edge where out_ready=1 unless a new op is accepted on the same edge. In that case the new result replaces the old with no bubble.
- ADD/SUB:
  - Modulo 2^WIDTH. SUB is computed as a + ~b + 1.
  - flag_carry is the carry out of bit WIDTH-1 (for SUB, 1 means no borrow).
  - flag_overflow = (sign a == sign of effective b) & (sign result != sign a).
- AND/OR/XOR: bitwise; carry=0, overflow=0.
- Shifts:
  - Amount is b[SHW-1:0]; amount 0 passes a unchanged.
  - SRA fills with a[WIDTH-1].
  - carry=0, overflow=0.
- SLT and SLTU: result is zero-extended 1/0 (signed and unsigned compare respectively); carry=0, overflow=0.
- MUL (MUL_EN=1):
  - The acceptance edge latches a and b, clears the accumulator and count, and enters MUL; busy=1.
  - Each of the next WIDTH edges processes one multiplier bit, LSB first, with a 2*WIDTH accumulator.
  - On the WIDTH-th edge: result = low WIDTH bits; flag_carry = high WIDTH bits nonzero; overflow=0; out_valid=1; state=IDLE; busy=0.
  - Latency is WIDTH+1 cycles. The unsigned product is exact modulo 2^WIDTH.
  - Any pending output must be consumed before acceptance, per the in_ready rule.
- Illegal op (11-15, or 10 with MUL_EN=0): accepted with latency 1; result=0, flag_zero=1, flag_illegal=1, other flags 0.
- flag_zero is computed on the final result for every op.
- flush (synchronous, highest priority after reset):
  - Forces state=IDLE, busy=0 and out_valid=0 on that edge; in_ready=0 in the flush cycle.
  - The result register keeps its value; flags are cleared.
- Simultaneous in_valid with flush or busy: not accepted; the requester must hold in_valid.

Test Plan:
- WIDTH=64: ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> next cycle result=0x8000_0000_0000_0000, overflow=1, carry=0, zero=0. Then SUB a=5, b=5 -> result=0, zero=1, carry=1, overflow=0.
- Shifts and compares:
  - SRA a=0x8000_0000_0000_0000, b=0x43 (amount 3) -> result=0xF000_0000_0000_0000.
  - SLTU a=1, b=0xFFFF_FFFF_FFFF_FFFF -> 1.
  - SLT with the same operands -> 0.
- MUL a=0x1_0000_0000, b=0x1_0000_0003 -> out_valid exactly 65 cycles after acceptance, result=0x3_0000_0000, carry=1, busy high for 64 cycles, in_ready=0 throughout.
- Backpressure: issue ADD 1+2 with out_ready=0 for 4 cycles -> result=3 stable, in_ready=0. Then out_ready=1 with XOR 0xF0^0xFF queued -> result=0x0F on the next cycle, no bubble.
- Abort: flush asserted 10 cycles into a MUL -> busy=0 and out_valid=0 on the next cycle, and no result appears. Separately, rst_n pulsed low mid-MUL -> all outputs 0 immediately, no clock required.
- WIDTH=8, MUL_EN=0: op=10 -> result=0, illegal=1, zero=1. MUL_EN=1: 0x10*0x11 -> result=0x10, carry=1, latency 9 cycles.

Source files
------------

// File: rtl/alu_seq_param.sv
// Registered, parametrised ALU with an iterative shift-add multiplier, status
// flags and valid/ready handshakes on both the request and the result side.
module alu_seq_param #(
    parameter int WIDTH  = 64,
    parameter int MUL_EN = 1,
    parameter int SHW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_overflow,
    output logic             flag_illegal,
    output logic             busy
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_e;

    state_e state_q, state_d;

    logic             accept;
    logic             is_sub;
    logic             is_mul;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_ill;

    logic             mul_last;
    logic [WIDTH-1:0] mul_lo;
    logic             mul_hi_nz;

    assign in_ready = rst_n && (state_q == S_IDLE) && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == S_MUL);

    assign is_sub = (op == OP_SUB);
    assign is_mul = (MUL_EN != 0) && (op == OP_MUL);
    assign b_eff  = is_sub ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    assign shamt  = b[SHW-1:0];

    // NOTE: every signal written in always_comb gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_ill   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_MUL: begin
                if (MUL_EN == 0) alu_ill = 1'b1;
            end
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && is_mul) state_d = S_MUL;
            S_MUL:   if (mul_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            logic [2*WIDTH-1:0] mcand;
            logic [2*WIDTH-1:0] acc;
            logic [2*WIDTH-1:0] acc_next;
            logic [WIDTH-1:0]   mplier;
            logic [SHW-1:0]     count;

            // One multiplier bit per cycle, LSB first; the multiplicand walks left.
            assign acc_next  = mplier[0] ? acc + mcand : acc;
            assign mul_last  = (state_q == S_MUL) && (count == SHW'(WIDTH - 1));
            assign mul_lo    = acc_next[WIDTH-1:0];
            assign mul_hi_nz = |acc_next[2*WIDTH-1:WIDTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mcand  <= '0;
                    acc    <= '0;
                    mplier <= '0;
                    count  <= '0;
                end else if (accept && is_mul) begin
                    mcand  <= {{WIDTH{1'b0}}, a};
                    acc    <= '0;
                    mplier <= b;
                    count  <= '0;
                end else if (state_q == S_MUL) begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + SHW'(1);
                end
            end
        end else begin : g_no_mul
            assign mul_last  = 1'b0;
            assign mul_lo    = '0;
            assign mul_hi_nz = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            result        <= '0;
            flag_zero     <= 1'b0;
            flag_carry    <= 1'b0;
            flag_overflow <= 1'b0;
            flag_illegal  <= 1'b0;
        end else if (flush) begin
            // The result register deliberately keeps its last value.
            out_valid     <= 1'b0;
            flag_zero     <= 1'b0;
            flag_carry    <= 1'b0;
            flag_overflow <= 1'b0;
            flag_illegal  <= 1'b0;
        end else if (accept && !is_mul) begin
            out_valid     <= 1'b1;
            result        <= alu_res;
            flag_zero     <= (alu_res == '0);
            flag_carry    <= alu_carry;
            flag_overflow <= alu_ovf;
            flag_illegal  <= alu_ill;
        end else if (mul_last) begin
            out_valid     <= 1'b1;
            result        <= mul_lo;
            flag_zero     <= (mul_lo == '0);
            flag_carry    <= mul_hi_nz;
            flag_overflow <= 1'b0;
            flag_illegal  <= 1'b0;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq_param.sv
// Scoreboard bench for alu_seq_param: a 64-bit instance with multiply, plus two
// 8-bit instances (with and without multiply) for the narrow-width cases.
module tb_alu_seq_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        in_ready, out_valid, busy;
    logic [63:0] result;
    logic        flag_zero, flag_carry, flag_overflow, flag_illegal;

    logic       in_valid8 = 1'b0;
    logic       out_ready8 = 1'b1;
    logic [3:0] op8 = 4'd0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       rdy_n, ov_n, z_n, c_n, v_n, i_n, busy_n;
    logic [7:0] res_n;
    logic       rdy_m, ov_m, z_m, c_m, v_m, i_m, busy_m;
    logic [7:0] res_m;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    string       q_tag[$];
    logic [63:0] q_res[$];
    logic [3:0]  q_flags[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_seq_param #(.WIDTH(64), .MUL_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_zero(flag_zero), .flag_carry(flag_carry),
        .flag_overflow(flag_overflow), .flag_illegal(flag_illegal), .busy(busy)
    );

    alu_seq_param #(.WIDTH(8), .MUL_EN(0)) u_w8n (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid8), .in_ready(rdy_n), .op(op8), .a(a8), .b(b8),
        .out_valid(ov_n), .out_ready(out_ready8), .result(res_n),
        .flag_zero(z_n), .flag_carry(c_n), .flag_overflow(v_n),
        .flag_illegal(i_n), .busy(busy_n)
    );

    alu_seq_param #(.WIDTH(8), .MUL_EN(1)) u_w8m (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid8), .in_ready(rdy_m), .op(op8), .a(a8), .b(b8),
        .out_valid(ov_m), .out_ready(out_ready8), .result(res_m),
        .flag_zero(z_m), .flag_carry(c_m), .flag_overflow(v_m),
        .flag_illegal(i_m), .busy(busy_m)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model; flags packed as {zero, carry, overflow, illegal}.
    task automatic model(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                         output logic [63:0] r, output logic [3:0] f);
        logic [64:0]  s;
        logic [127:0] p;
        logic         c, v, il;
        r = '0; c = 1'b0; v = 1'b0; il = 1'b0;
        case (o)
            4'd0: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[63:0];
                c = s[64];
                v = (x[63] == y[63]) && (r[63] != x[63]);
            end
            4'd1: begin
                r = x - y;
                c = (x >= y);
                v = (x[63] != y[63]) && (r[63] != x[63]);
            end
            4'd2:  r = x & y;
            4'd3:  r = x | y;
            4'd4:  r = x ^ y;
            4'd5:  r = x << y[5:0];
            4'd6:  r = x >> y[5:0];
            4'd7:  r = $signed(x) >>> y[5:0];
            4'd8:  r = {63'd0, $signed(x) < $signed(y)};
            4'd9:  r = {63'd0, x < y};
            4'd10: begin
                p = {64'd0, x} * {64'd0, y};
                r = p[63:0];
                c = |p[127:64];
            end
            default: il = 1'b1;
        endcase
        f = {(r == 64'd0), c, v, il};
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input string tag, input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        logic [63:0] r;
        logic [3:0]  f;
        int          n;
        op = o; a = x; b = y; in_valid = 1'b1; n = 0;
        #1;
        while (!in_ready && n < 300) begin
            @(negedge clk); #1; n++;
        end
        if (!in_ready) begin
            check({tag, "_accept_timeout"}, in_ready, 1);
        end else begin
            model(o, x, y, r, f);
            q_tag.push_back(tag);
            q_res.push_back(r);
            q_flags.push_back(f);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (q_res.size() != 0 && n < 400) begin
            @(negedge clk); n++;
        end
        check({tag, "_drain"}, q_res.size(), 0);
        @(negedge clk);
    endtask

    task automatic discard_last();
        if (q_res.size() != 0) begin
            void'(q_tag.pop_back());
            void'(q_res.pop_back());
            void'(q_flags.pop_back());
        end
    endtask

    // Output monitor: compares each consumed result against the scoreboard.
    always @(negedge clk) begin : monitor
        string t;
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (q_res.size() == 0) begin
                check("unexpected_output", out_valid, 0);
            end else begin
                t = q_tag.pop_front();
                check({t, "_res"}, result, q_res.pop_front());
                check({t, "_flags"}, {flag_zero, flag_carry, flag_overflow, flag_illegal},
                      q_flags.pop_front());
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   n, busy_cnt, rdy_bad, hold_bad, c0;
        logic rand_bp;

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_result", result, 0);
        check("rst_flags", {flag_zero, flag_carry, flag_overflow, flag_illegal, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1 check("ready_after_rst", in_ready, 1);
        @(negedge clk);

        // Directed single-cycle ops, issued back to back.
        issue("add_ovf", 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        #1 check("add_latency", out_valid, 1);
        @(negedge clk);
        issue("sub_zero",   4'd1, 64'd5, 64'd5);
        issue("sra3",       4'd7, 64'h8000_0000_0000_0000, 64'h43);
        issue("sltu",       4'd9, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        issue("slt",        4'd8, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        issue("sll_amt0",   4'd5, 64'h1234_5678_9ABC_DEF0, 64'h40);
        issue("srl63",      4'd6, 64'h8000_0000_0000_0001, 64'd63);
        issue("add_carry",  4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        issue("sub_borrow", 4'd1, 64'd0, 64'd1);
        issue("sub_ovf",    4'd1, 64'h8000_0000_0000_0000, 64'd1);
        issue("and",        4'd2, 64'hF0F0_0000_FFFF_1234, 64'h0FF0_FFFF_00FF_FFFF);
        issue("or",         4'd3, 64'hF000_0000_0000_0001, 64'h0000_0000_0000_0100);
        issue("illegal12",  4'd12, 64'hDEAD, 64'hBEEF);
        drain("directed");

        // Throughput: one accepted op per cycle with out_ready high.
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] o;
            o = 4'($urandom_range(0, 15));
            if (o == 4'd10) o = 4'd11;
            issue($sformatf("burst%0d", i), o, rnd64(), rnd64());
        end
        check("burst_cycles", cyc - c0, 16);
        drain("burst");

        // Multiply timing and busy/in_ready behaviour.
        issue("mul64", 4'd10, 64'h1_0000_0000, 64'h1_0000_0003);
        n = 1; busy_cnt = 0; rdy_bad = 0;
        #1;
        while (!out_valid && n < 200) begin
            busy_cnt += int'(busy);
            rdy_bad  += int'(in_ready);
            @(negedge clk); #1; n++;
        end
        check("mul_latency", n, 65);
        check("mul_busy_cycles", busy_cnt, 64);
        check("mul_in_ready_low", rdy_bad, 0);
        check("mul_busy_done", busy, 0);
        drain("mul64");
        issue("mul_rand", 4'd10, {$urandom, $urandom}, {$urandom, $urandom});
        drain("mul_rand");

        // Backpressure: result holds, then a queued op replaces it without a bubble.
        out_ready = 1'b0;
        issue("bp_add", 4'd0, 64'd1, 64'd2);
        hold_bad = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (result !== 64'd3 || out_valid !== 1'b1 || in_ready !== 1'b0) hold_bad++;
            @(negedge clk);
        end
        check("bp_hold", hold_bad, 0);
        out_ready = 1'b1;
        issue("bp_xor", 4'd4, 64'hF0, 64'hFF);
        #1;
        check("bp_no_bubble", out_valid, 1);
        check("bp_xor_value", result, 64'h0F);
        @(negedge clk);
        drain("bp");

        // Flush ten cycles into a multiply.
        issue("flush_mul", 4'd10, {$urandom, $urandom} | 64'd1, {$urandom, $urandom});
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1 check("flush_in_ready", in_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        discard_last();
        #1;
        check("flush_busy", busy, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_result_kept", result, 64'h0F);
        check("flush_flags", {flag_zero, flag_carry, flag_overflow, flag_illegal}, 0);
        repeat (80) @(negedge clk);

        // Asynchronous reset in the middle of a multiply.
        issue("rst_mul", 4'd10, 64'h1234_5678, 64'h9ABC_DEF1);
        repeat (5) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_result", result, 0);
        check("arst_flags", {flag_zero, flag_carry, flag_overflow, flag_illegal}, 0);
        discard_last();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);

        // Random mix, including multiplies, under random backpressure.
        rand_bp = 1'b1;
        fork
            begin
                while (rand_bp) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 30; i++)
                    issue($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), rnd64(), rnd64());
                rand_bp = 1'b0;
            end
        join
        out_ready = 1'b1;
        drain("random");

        // 8-bit instances: op 10 is illegal without multiply, a 9-cycle multiply with it.
        op8 = 4'd10; a8 = 8'h10; b8 = 8'h11; in_valid8 = 1'b1;
        #1 check("w8_ready", {rdy_n, rdy_m}, 2'b11);
        @(negedge clk);
        in_valid8 = 1'b0;
        #1;
        check("w8n_valid", ov_n, 1);
        check("w8n_res", res_n, 8'h00);
        check("w8n_flags", {z_n, c_n, v_n, i_n}, 4'b1001);
        n = 1;
        while (!ov_m && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check("w8m_latency", n, 9);
        check("w8m_res", res_m, 8'h10);
        check("w8m_flags", {z_m, c_m, v_m, i_m}, 4'b0100);
        @(negedge clk);
        op8 = 4'd5; a8 = 8'h81; b8 = 8'h0B; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        #1;
        check("w8n_sll", res_n, 8'h08);
        check("w8m_sll", res_m, 8'h08);

        check("final_queue_empty", q_res.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
